// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side loader for the byte-addressed, big-endian instruction memory.
//   Takes a host byte stream over a valid/ready handshake and writes one byte
//   per cycle at sequential addresses, starting from a word-aligned base. The
//   CPU is held off with CPU_HOLD while a load is in progress. Every 4-byte
//   group is also reassembled into the big-endian word that fetch will see.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     Adds EXP_CSUM (latched at START accept) and CSUM (mod-256 sum of the
//     bytes of the current load). A mismatch raises ERROR together with DONE.
//
// Ports
//   CLK, RESET        clock; asynchronous active-high reset
//   START, ABORT      begin a load (IDLE only) / cancel a load (LOAD only)
//   BASE_ADDR         first byte address, must be word-aligned
//   BYTE_COUNT        bytes to load, 1..2^ADDR_W
//   IN_DATA/VALID     stream byte and its valid; IN_READY is the loader's ready
//   MEM_ADDR/WDATA/WE memory write port, one byte per strobe
//   CPU_HOLD, BUSY    hold for the fetch path / loader active (LOAD, DONE)
//   DONE, ERROR       completion pulse / rejected START, ABORT or bad checksum
//   WORD_OUT/VALID    last assembled big-endian word and its update pulse
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   BYTE_COUNT,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [7:0]        EXP_CSUM,
  output logic [7:0]        CSUM,
`endif
  output logic              IN_READY,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  output logic              MEM_WE,
  output logic              CPU_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [31:0]       WORD_OUT,
  output logic              WORD_VALID
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W+1:0] MEM_BYTES = {2'b01, {ADDR_W{1'b0}}};

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [31:0]       asm_word, asm_next;
  logic [ADDR_W+1:0] end_addr;
  logic              start_bad, start_ok, start_rej;
  logic              accept, last_byte, word_end;

  // One extra bit beyond ADDR_W+1 so an oversize BYTE_COUNT cannot wrap the
  // sum back into range; for legal counts the result is identical.
  assign end_addr  = {2'b00, BASE_ADDR} + {1'b0, BYTE_COUNT};
  assign start_bad = (BYTE_COUNT == '0) || (BASE_ADDR[1:0] != 2'b00) ||
                     (end_addr > MEM_BYTES);
  assign start_ok  = (state == S_IDLE) && START && !start_bad;
  assign start_rej = (state == S_IDLE) && START &&  start_bad;

  // ABORT wins over a byte offered in the same cycle: that byte is dropped.
  assign accept    = (state == S_LOAD) && IN_VALID && !ABORT;
  assign last_byte = (rem == (ADDR_W+1)'(1));
  assign word_end  = (ptr[1:0] == 2'd3) || last_byte;

  // Lane 0 starts a fresh word, so unfilled low lanes of a short final word
  // read as zero.
  always_comb begin
    asm_next = (ptr[1:0] == 2'd0) ? 32'h0 : asm_word;
    unique case (ptr[1:0])
      2'd0: asm_next[31:24] = IN_DATA;
      2'd1: asm_next[23:16] = IN_DATA;
      2'd2: asm_next[15:8]  = IN_DATA;
      2'd3: asm_next[7:0]   = IN_DATA;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    CPU_HOLD   = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    unique case (state)
      S_IDLE: if (start_ok) state_next = S_LOAD;
      S_LOAD: begin
        IN_READY = 1'b1;
        CPU_HOLD = 1'b1;
        BUSY     = 1'b1;
        if (ABORT)                    state_next = S_IDLE;
        else if (accept && last_byte) state_next = S_DONE;
      end
      S_DONE: begin
        CPU_HOLD   = 1'b1;
        BUSY       = 1'b1;
        DONE       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] exp_csum_q;
  logic [7:0] csum_next;
  assign csum_next = CSUM + IN_DATA;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ptr        <= '0;
      rem        <= '0;
      asm_word   <= '0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WE     <= 1'b0;
      ERROR      <= 1'b0;
      WORD_OUT   <= '0;
      WORD_VALID <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM       <= '0;
      exp_csum_q <= '0;
`endif
    end else begin
      MEM_WE     <= 1'b0;
      WORD_VALID <= 1'b0;
      ERROR      <= start_rej || ((state == S_LOAD) && ABORT);

      if (start_ok) begin
        ptr      <= BASE_ADDR;
        rem      <= BYTE_COUNT;
        asm_word <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM       <= '0;
        exp_csum_q <= EXP_CSUM;
`endif
      end

      if (accept) begin
        MEM_WE    <= 1'b1;
        MEM_ADDR  <= ptr;
        MEM_WDATA <= IN_DATA;
        ptr       <= ptr + ADDR_W'(1);
        rem       <= rem - (ADDR_W+1)'(1);
        asm_word  <= asm_next;
        if (word_end) begin
          WORD_OUT   <= asm_next;
          WORD_VALID <= 1'b1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Summed at acceptance so the total is complete in the DONE cycle.
        CSUM <= csum_next;
        if (last_byte && (csum_next != exp_csum_q)) ERROR <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Inputs are driven 1 time unit after the
//   rising edge; a negedge monitor mirrors memory writes into a byte array,
//   collects assembled words and counts DONE/ERROR pulses and write strobes
//   that do not follow an accepted byte by exactly one cycle.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RESET, START, ABORT, IN_VALID;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [ADDR_W:0]   BYTE_COUNT;
  logic [7:0]        IN_DATA;
  logic              IN_READY, MEM_WE, CPU_HOLD, BUSY, DONE, ERROR, WORD_VALID;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic [31:0]       WORD_OUT;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        EXP_CSUM, CSUM;
`endif

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .BASE_ADDR(BASE_ADDR), .BYTE_COUNT(BYTE_COUNT),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .EXP_CSUM(EXP_CSUM), .CSUM(CSUM),
`endif
    .IN_READY(IN_READY), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WE(MEM_WE), .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE),
    .ERROR(ERROR), .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mem [0:1023];
  logic [31:0] words [$];
  logic [7:0]  stim [0:7];
  int          we_count = 0, we_bad = 0, done_count = 0, err_count = 0, done_err = 0;
  bit          acc_prev = 1'b0;

  // A write strobe must appear exactly one cycle after each accepted byte
  // and never otherwise; reset cancels any pending write.
  always @(negedge CLK) begin
    if (MEM_WE !== (acc_prev && !RESET)) we_bad++;
    acc_prev = IN_VALID && IN_READY && !ABORT && !RESET;
    if (MEM_WE === 1'b1) begin
      mem[MEM_ADDR] = MEM_WDATA;
      we_count++;
    end
    if (WORD_VALID === 1'b1) words.push_back(WORD_OUT);
    if (DONE === 1'b1)  done_count++;
    if (ERROR === 1'b1) err_count++;
    if (DONE === 1'b1 && ERROR === 1'b1) done_err++;
  end

  function automatic logic [56:0] all_outs();
    return {IN_READY, MEM_WE, CPU_HOLD, BUSY, DONE, ERROR, WORD_VALID,
            MEM_ADDR, MEM_WDATA, WORD_OUT};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    words.delete();
    we_count = 0; we_bad = 0; done_count = 0; err_count = 0; done_err = 0;
  endtask

  task automatic start_load(input int base, input int count);
    BASE_ADDR  = ADDR_W'(base);
    BYTE_COUNT = (ADDR_W+1)'(count);
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  // Presents stim[first..first+n-1]; each byte is held until an edge where
  // IN_READY is high. Optional one-cycle bubble between bytes.
  task automatic stream(input int first, input int n, input bit bubble);
    for (int i = first; i < first + n; i++) begin
      if (bubble && i > first) begin
        IN_VALID = 1'b0;
        tick();
      end
      IN_DATA  = stim[i];
      IN_VALID = 1'b1;
      for (int g = 0; g < 16 && !IN_READY; g++) tick();
      if (!IN_READY) begin
        n_tests++; n_fail++;
        $display("FAIL ready_timeout: IN_READY=%b required 1 for byte %0d", IN_READY, i);
      end
      tick();
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    n_tests++;
    if (all_outs() !== 57'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    RESET = 1'b0;
    tick();
    n_tests++;
    if ({CPU_HOLD, BUSY, IN_READY} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: hold/busy/ready=%b required 000", {CPU_HOLD, BUSY, IN_READY});
    end
  endtask

  task automatic test_nominal();
    stim = '{8'h08, 8'h01, 8'h10, 8'h00, 8'h00, 8'h64, 8'h28, 8'h00};
    clear_log();
    start_load(0, 8);
    n_tests++;
    if ({CPU_HOLD, BUSY, IN_READY, DONE, ERROR} !== 5'b11100) begin
      n_fail++;
      $display("FAIL load_entry: hold/busy/ready/done/err=%b required 11100",
               {CPU_HOLD, BUSY, IN_READY, DONE, ERROR});
    end
    stream(0, 1, 1'b0);
    n_tests++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 10'd0, 8'h08}) begin
      n_fail++;
      $display("FAIL first_write: we/addr/data=%b/%0d/%h required 1/0/08", MEM_WE, MEM_ADDR, MEM_WDATA);
    end
    stream(1, 7, 1'b0);
    n_tests++;
    if ({DONE, CPU_HOLD, BUSY, IN_READY, MEM_WE, MEM_ADDR} !== {5'b11101, 10'd7}) begin
      n_fail++;
      $display("FAIL done_cycle: done/hold/busy/ready/we=%b addr=%0d required 11101 addr 7",
               {DONE, CPU_HOLD, BUSY, IN_READY, MEM_WE}, MEM_ADDR);
    end
    tick();
    n_tests++;
    if ({DONE, CPU_HOLD, BUSY} !== 3'b000) begin
      n_fail++;
      $display("FAIL hold_release: done/hold/busy=%b required 000", {DONE, CPU_HOLD, BUSY});
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (mem[i] !== stim[i]) begin
        n_fail++;
        $display("FAIL nominal_mem[%0d]: got %h required %h", i, mem[i], stim[i]);
      end
    end
    n_tests++;
    if (words.size() !== 2 || words[0] !== 32'h08011000 || words[1] !== 32'h00642800) begin
      n_fail++;
      $display("FAIL nominal_words: got %0d words first %h last %h required 2 words 08011000 00642800",
               words.size(), words.size() > 0 ? words[0] : 32'h0, words.size() > 1 ? words[1] : 32'h0);
    end
    n_tests++;
    if ({we_count, done_count, err_count, we_bad} !== {32'd8, 32'd1, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL nominal_counts: writes=%0d done=%0d err=%0d bad_we=%0d required 8 1 0 0",
               we_count, done_count, err_count, we_bad);
    end
  endtask

  task automatic test_bubbles();
    clear_log();
    start_load(0, 8);
    stream(0, 8, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (mem[i] !== stim[i]) begin
        n_fail++;
        $display("FAIL bubble_mem[%0d]: got %h required %h", i, mem[i], stim[i]);
      end
    end
    n_tests++;
    if (words.size() !== 2 || words[0] !== 32'h08011000 || words[1] !== 32'h00642800) begin
      n_fail++;
      $display("FAIL bubble_words: got %0d words, required 08011000 00642800", words.size());
    end
    n_tests++;
    if ({we_count, we_bad, done_count, done_err} !== {32'd8, 32'd0, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL bubble_counts: writes=%0d bad_we=%0d done=%0d done_err=%0d required 8 0 1 0",
               we_count, we_bad, done_count, done_err);
    end
  endtask

  task automatic test_rejects();
    int bases  [3] = '{2, 0, 1020};
    int counts [3] = '{4, 0, 8};
    clear_log();
    for (int k = 0; k < 3; k++) begin
      start_load(bases[k], counts[k]);
      n_tests++;
      if ({ERROR, BUSY, CPU_HOLD, IN_READY} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reject_%0d: err/busy/hold/ready=%b required 1000", k, {ERROR, BUSY, CPU_HOLD, IN_READY});
      end
      tick();
      n_tests++;
      if (ERROR !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_pulse_%0d: ERROR=%b required 0", k, ERROR);
      end
    end
    // Exactly filling the top of memory is legal.
    start_load(1020, 4);
    n_tests++;
    if ({BUSY, ERROR} !== 2'b10) begin
      n_fail++;
      $display("FAIL top_fit_accept: busy/err=%b required 10", {BUSY, ERROR});
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    tick();
    n_tests++;
    if ({we_count, err_count} !== {32'd0, 32'd4}) begin
      n_fail++;
      $display("FAIL reject_counts: writes=%0d err=%0d required 0 4", we_count, err_count);
    end
  endtask

  task automatic test_partial_boundary();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
    clear_log();
    start_load(1016, 6);
    stream(0, 6, 1'b0);
    n_tests++;
    if ({DONE, MEM_WE, WORD_VALID, MEM_ADDR, WORD_OUT} !== {3'b111, 10'd1021, 32'hEEFF0000}) begin
      n_fail++;
      $display("FAIL partial_done: done/we/wv=%b addr=%0d word=%h required 111 1021 eeff0000",
               {DONE, MEM_WE, WORD_VALID}, MEM_ADDR, WORD_OUT);
    end
    tick();
    tick();
    n_tests++;
    if (words.size() !== 2 || words[0] !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL partial_words: got %0d words, required aabbccdd then eeff0000", words.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (mem[1016+i] !== stim[i]) begin
        n_fail++;
        $display("FAIL partial_mem[%0d]: got %h required %h", 1016 + i, mem[1016+i], stim[i]);
      end
    end
    n_tests++;
    if ({we_count, done_count, we_bad} !== {32'd6, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL partial_counts: writes=%0d done=%0d bad_we=%0d required 6 1 0", we_count, done_count, we_bad);
    end
  endtask

  task automatic test_abort();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_log();
    start_load(0, 8);
    stream(0, 3, 1'b0);
    IN_DATA  = stim[3];
    IN_VALID = 1'b1;
    ABORT    = 1'b1;
    tick();
    n_tests++;
    if ({ERROR, CPU_HOLD, IN_READY, BUSY, MEM_WE} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_next: err/hold/ready/busy/we=%b required 10000",
               {ERROR, CPU_HOLD, IN_READY, BUSY, MEM_WE});
    end
    ABORT    = 1'b0;
    IN_VALID = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h11223300) begin
      n_fail++;
      $display("FAIL abort_mem: got %h required 11223300", {mem[0], mem[1], mem[2], mem[3]});
    end
    n_tests++;
    if ({we_count, err_count, done_count, we_bad, words.size()} !== {32'd3, 32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL abort_counts: writes=%0d err=%0d done=%0d bad_we=%0d words=%0d required 3 1 0 0 0",
               we_count, err_count, done_count, we_bad, words.size());
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load(0, 8);
    stream(0, 3, 1'b0);
    IN_DATA  = stim[3];
    IN_VALID = 1'b1;
    @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    n_tests++;
    if (all_outs() !== 57'h0) begin
      n_fail++;
      $display("FAIL reset_mid_load: got %h required 0", all_outs());
    end
    tick();
    tick();
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({we_count, we_bad, BUSY, 24'(mem[3])} !== {32'd3, 32'd0, 1'b0, 24'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_counts: writes=%0d bad_we=%0d busy=%b mem3=%h required 3 0 0 00",
               we_count, we_bad, BUSY, mem[3]);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    EXP_CSUM = 8'h0A;
    start_load(0, 4);
    stream(0, 4, 1'b0);
    n_tests++;
    if ({DONE, ERROR, CSUM} !== {2'b10, 8'h0A}) begin
      n_fail++;
      $display("FAIL csum_match: done/err=%b csum=%h required 10 0a", {DONE, ERROR}, CSUM);
    end
    tick();
    n_tests++;
    if (CSUM !== 8'h0A) begin
      n_fail++;
      $display("FAIL csum_hold: got %h required 0a", CSUM);
    end
    EXP_CSUM = 8'h0B;
    start_load(0, 4);
    stream(0, 4, 1'b0);
    n_tests++;
    if ({DONE, ERROR, CSUM} !== {2'b11, 8'h0A}) begin
      n_fail++;
      $display("FAIL csum_mismatch: done/err=%b csum=%h required 11 0a", {DONE, ERROR}, CSUM);
    end
    tick();
  endtask
`endif

  initial begin
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; IN_VALID = 1'b0;
    IN_DATA = '0; BASE_ADDR = '0; BYTE_COUNT = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    EXP_CSUM = '0;
`endif
    test_reset();
    test_nominal();
    test_bubbles();
    test_rejects();
    test_partial_boundary();
    test_abort();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
